pipelined_cla_addsub: RTL and testbench

PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

---
 rtl/pipelined_cla_addsub_pkg.sv | 9 +
 rtl/pipelined_cla_addsub_cla_group.sv | 46 ++++
 rtl/pipelined_cla_addsub.sv | 121 ++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_cla_addsub_pkg.sv
// Shared constants for the pipelined carry-lookahead add/subtract unit.
package pipelined_cla_addsub_pkg;

   localparam logic OP_ADD        = 1'b0;
   localparam logic OP_SUB        = 1'b1;
   localparam int   DEFAULT_GROUP = 4;
   localparam int   DEFAULT_WIDTH = 16;

endpackage

// File: rtl/pipelined_cla_addsub_cla_group.sv
// GROUP-bit combinational carry-lookahead block; every carry is a flat
// sum-of-products of g/p/cin so no carry waits on a lower carry.
module cla_group #(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] b,
   input  logic             cin,
   output logic [GROUP-1:0] sum,
   output logic             cout,
   output logic             gp,
   output logic             gg
);

   logic [GROUP-1:0] p;
   logic [GROUP-1:0] g;
   logic [GROUP:0]   gen;
   logic [GROUP:0]   prop;
   logic [GROUP:0]   c;

   always_comb begin
      logic t;
      t    = 1'b0;
      p    = a ^ b;
      g    = a & b;
      gen  = '0;
      prop = '0;
      c    = '0;
      // gen[i]: carry into bit i generated inside the group; prop[i]: cin passes to bit i
      for (int i = 0; i <= GROUP; i++) begin
         prop[i] = 1'b1;
         for (int m = 0; m < i; m++) prop[i] = prop[i] & p[m];
         for (int j = 0; j < i; j++) begin
            t = g[j];
            for (int m = j + 1; m < i; m++) t = t & p[m];
            gen[i] = gen[i] | t;
         end
         c[i] = gen[i] | (prop[i] & cin);
      end
      sum  = p ^ c[GROUP-1:0];
      cout = c[GROUP];
      gp   = prop[GROUP];
      gg   = gen[GROUP];
   end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// Skewed-pipeline add/subtract: stage k resolves bit group k, carrying the
// untouched operand bits and finished sum bits along with the data.
module pipelined_cla_addsub
   import pipelined_cla_addsub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int GROUP = DEFAULT_GROUP
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = WIDTH / GROUP;
   localparam int L      = STAGES - 1;

   logic [STAGES-1:0]            vld_q, vld_d, c_q, c_d;
   logic [STAGES-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic                         ovf_q, ovf_d, zero_q, zero_d;

   logic [STAGES-1:0]            v_in, c_in, grp_c, grp_p, grp_g;
   logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, s_in;
   logic [STAGES-1:0][GROUP-1:0] grp_s;
   logic                         stall;
   logic                         unused_bits;

   assign stall     = vld_q[L] & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = vld_q[L];
   assign Sum       = s_q[L];
   assign cout      = c_q[L];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         if (k == 0) begin : g_head
            // subtract folds into add: A + ~B + ~cin
            assign v_in[k] = in_valid;
            assign a_in[k] = A;
            assign b_in[k] = (op == OP_SUB) ? ~B : B;
            assign c_in[k] = (op == OP_SUB) ? ~cin : cin;
            assign s_in[k] = '0;
         end else begin : g_body
            assign v_in[k] = vld_q[k-1];
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign s_in[k] = s_q[k-1];
         end
         cla_group #(.GROUP(GROUP)) u_grp (
            .a    (a_in[k][k*GROUP +: GROUP]),
            .b    (b_in[k][k*GROUP +: GROUP]),
            .cin  (c_in[k]),
            .sum  (grp_s[k]),
            .cout (grp_c[k]),
            .gp   (grp_p[k]),
            .gg   (grp_g[k])
         );
      end
   endgenerate

   // operand bits already consumed and the last stage's copy are dead ends
   assign unused_bits = ^{a_in, b_in, a_q[L], b_q[L], grp_p, grp_g};

   always_comb begin
      vld_d  = vld_q;
      c_d    = c_q;
      a_d    = a_q;
      b_d    = b_q;
      s_d    = s_q;
      ovf_d  = ovf_q;
      zero_d = zero_q;
      if (!stall) begin
         for (int i = 0; i < STAGES; i++) begin
            vld_d[i] = v_in[i];
            c_d[i]   = grp_c[i];
            a_d[i]   = a_in[i];
            b_d[i]   = b_in[i];
            s_d[i]   = s_in[i];
            s_d[i][i*GROUP +: GROUP] = grp_s[i];
         end
         ovf_d  = (a_in[L][WIDTH-1] == b_in[L][WIDTH-1]) &&
                  (s_d[L][WIDTH-1] != a_in[L][WIDTH-1]);
         zero_d = (s_d[L] == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q  <= '0;
         c_q    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else begin
         vld_q  <= vld_d;
         c_q    <= c_d;
         a_q    <= a_d;
         b_q    <= b_d;
         s_q    <= s_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Randomised bench for pipelined_cla_addsub (WIDTH=16 and a WIDTH=4 instance)
// against an integer-arithmetic reference model.
module tb_pipelined_cla_addsub;
   import pipelined_cla_addsub_pkg::*;

   localparam int W  = 16;
   localparam int ST = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, op, cin, out_valid, out_ready, cout, ovf, zero;
   logic [W-1:0]  A, B, Sum;
   logic          v4, rdy4, op4, c4, ov4, or4, co4, of4, z4;
   logic [3:0]    a4, b4, s4;

   always #5 clk = ~clk;

   pipelined_cla_addsub #(.WIDTH(16), .GROUP(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .Sum(Sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   pipelined_cla_addsub #(.WIDTH(4), .GROUP(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(v4), .in_ready(rdy4),
      .A(a4), .B(b4), .op(op4), .cin(c4), .out_valid(ov4), .out_ready(or4),
      .Sum(s4), .cout(co4), .ovf(of4), .zero(z4)
   );

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      logic        zero;
      int          cyc;
      int          stl;
   } exp_t;

   exp_t        q[$];
   exp_t        e;
   int          ncmp = 0, nbad = 0, cyc = 0, stall_total = 0, stall_left = 0;
   bit          rand_ready = 0, prev_stall = 0, stall_now;
   logic [15:0] held_s;
   logic [2:0]  held_f;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(int w, logic [15:0] a, logic [15:0] b, logic o, logic c);
      exp_t   r;
      longint mask, half, full, sa, sb, sr;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      if (o == OP_ADD) full = longint'(a) + longint'(b) + longint'(c);
      else             full = longint'(a) + ((~longint'(b)) & mask) + longint'(!c);
      sa = longint'(a); if (sa >= half) sa = sa - 2 * half;
      sb = longint'(b); if (sb >= half) sb = sb - 2 * half;
      sr = (o == OP_ADD) ? sa + sb + longint'(c) : sa - sb - longint'(c);
      r.sum  = 16'(full & mask);
      r.cout = ((full >> w) & 1) != 0;
      r.ovf  = (sr >= half) || (sr < -half);
      r.zero = (full & mask) == 0;
      r.cyc  = 0;
      r.stl  = 0;
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // scoreboard: every delivered result, every stall cycle, every acceptance
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (q.size() == 0) begin
            ncmp++; nbad++;
            $display("FAIL unexpected_out: got Sum %0h expected no result", Sum);
         end else begin
            e = q.pop_front();
            chk("sum",     32'(Sum),  32'(e.sum));
            chk("cout",    32'(cout), 32'(e.cout));
            chk("ovf",     32'(ovf),  32'(e.ovf));
            chk("zero",    32'(zero), 32'(e.zero));
            chk("latency", 32'(cyc - e.cyc), 32'(ST + stall_total - e.stl));
         end
      end
      stall_now = (out_valid === 1'b1 && out_ready === 1'b0);
      if (stall_now) begin
         chk("in_ready_stall", 32'(in_ready), 32'd0);
         if (prev_stall) chk("frozen", 32'({Sum, cout, ovf, zero}), 32'({held_s, held_f}));
         held_s = Sum;
         held_f = {cout, ovf, zero};
      end
      prev_stall = stall_now;
      if (reset) q.delete();
      else if (in_valid === 1'b1 && in_ready === 1'b1) begin
         e     = model(W, A, B, op, cin);
         e.cyc = cyc;
         e.stl = stall_total;
         q.push_back(e);
      end
      if (stall_now) stall_total++;
   end

   task automatic upd_ready();
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      else begin
         out_ready = (stall_left == 0);
         if (stall_left > 0) stall_left--;
      end
   endtask

   task automatic drive(bit v, logic [15:0] a, logic [15:0] b, logic o, logic c);
      bit ok;
      int guard;
      guard = 0;
      in_valid = v; A = a; B = b; op = o; cin = c;
      upd_ready();
      do begin
         @(negedge clk);
         ok = !v || (in_ready === 1'b1);
         @(posedge clk); #1;
         guard++;
         if (!ok) upd_ready();
      end while (!ok && guard < 40);
      if (!ok) begin
         ncmp++; nbad++;
         $display("FAIL accept_timeout: got in_ready %0b expected 1", in_ready);
      end
   endtask

   task automatic idle(int n);
      repeat (n) drive(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic rnd_op();
      drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
   endtask

   task automatic lit(string nm, logic [15:0] a, logic [15:0] b, logic o, logic c,
                      logic [15:0] es, logic ec, logic eo, logic ez);
      int t0, n;
      t0 = cyc;
      n  = 0;
      drive(1'b1, a, b, o, c);
      in_valid = 1'b0;
      do begin @(negedge clk); n++; end while (out_valid !== 1'b1 && n < 12);
      chk({nm, "_lat"},  32'(cyc - t0), 32'(ST));
      chk({nm, "_sum"},  32'(Sum),  32'(es));
      chk({nm, "_cout"}, 32'(cout), 32'(ec));
      chk({nm, "_ovf"},  32'(ovf),  32'(eo));
      chk({nm, "_zero"}, 32'(zero), 32'(ez));
      @(posedge clk); #1;
   endtask

   task automatic d4(string nm, logic [3:0] a, logic [3:0] b, logic o, logic c, exp_t x);
      v4 = 1'b1; a4 = a; b4 = b; op4 = o; c4 = c;
      @(negedge clk);
      chk({nm, "_bubble"}, 32'(ov4), 32'd0);
      @(posedge clk); #1;
      v4 = 1'b0;
      @(negedge clk);
      chk({nm, "_valid"}, 32'(ov4), 32'd1);
      chk({nm, "_sum"},   32'(s4),  32'(x.sum[3:0]));
      chk({nm, "_cout"},  32'(co4), 32'(x.cout));
      chk({nm, "_ovf"},   32'(of4), 32'(x.ovf));
      chk({nm, "_zero"},  32'(z4),  32'(x.zero));
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; A = '0; B = '0; op = 1'b0; cin = 1'b0; out_ready = 1'b1;
      v4 = 1'b0; a4 = '0; b4 = '0; op4 = 1'b0; c4 = 1'b0; or4 = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(Sum),       32'd0);
      chk("rst_flags",     32'({cout, ovf, zero}), 32'd0);
      chk("rst4_out_valid", 32'(ov4), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_after_rst", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      lit("ffff_plus_1", 16'hFFFF, 16'h0001, OP_ADD, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      lit("7fff_plus_1", 16'h7FFF, 16'h0001, OP_ADD, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      lit("3_minus_5",   16'h0003, 16'h0005, OP_SUB, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
      lit("8000_minus_1", 16'h8000, 16'h0001, OP_SUB, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
      lit("add_cin",     16'h1234, 16'h0FFF, OP_ADD, 1'b1, 16'h2234, 1'b0, 1'b0, 1'b0);
      lit("sub_bin",     16'h0005, 16'h0005, OP_SUB, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

      // back-to-back stream
      idle(2);
      repeat (8) rnd_op();
      idle(8);

      // full pipeline held for three cycles
      repeat (5) rnd_op();
      stall_left = 3;
      repeat (6) rnd_op();
      idle(10);

      // random traffic with random backpressure and bubbles
      rand_ready = 1;
      repeat (300) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else rnd_op();
      end
      rand_ready = 0;
      for (int i = 0; i < 40 && q.size() != 0; i++) idle(1);
      chk("drain", 32'(q.size()), 32'd0);

      // reset with three operations in flight
      idle(6);
      repeat (3) rnd_op();
      reset = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_sum",       32'(Sum), 32'd0);
      chk("flush_flags",     32'({cout, ovf, zero}), 32'd0);
      chk("flush_in_ready",  32'(in_ready), 32'd1);
      @(posedge clk); #1;
      idle(8);

      // single-stage instance
      d4("w4_9_plus_8", 4'h9, 4'h8, OP_ADD, 1'b1,
         '{sum: 16'h2, cout: 1'b1, ovf: 1'b1, zero: 1'b0, cyc: 0, stl: 0});
      d4("w4_5_minus_7", 4'h5, 4'h7, OP_SUB, 1'b1,
         '{sum: 16'hD, cout: 1'b0, ovf: 1'b0, zero: 1'b0, cyc: 0, stl: 0});
      repeat (16) begin
         logic [3:0] ra, rb;
         logic       ro, rc;
         ra = 4'($urandom); rb = 4'($urandom);
         ro = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
         d4("w4_rand", ra, rb, ro, rc, model(4, 16'(ra), 16'(rb), ro, rc));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule
